pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
// - Consumer end of the control-decoder interface. Fetches instructions and hands them to decode.
// - Takes back the resolved branch[2:0], jump[1:0] and jr codes plus rs/rt operand values.
// - Computes the next PC and the jal link write.
// - Multicycle fetch/issue/resolve FSM, one instruction in flight, no delay slot.
// PARAMETERS
// - XLEN      32            data/address width
// - RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
// - clk            in   1     single clock, rising edge
// - rst_n          in   1     asynchronous active-low reset
// - halt           in   1     when high, no new fetch is started
// - imem_req       out  1     instruction fetch request
// - imem_addr      out  XLEN  fetch address (= pc)
// - imem_ready     in   1     fetch done; imem_rdata valid this cycle
// - imem_rdata     in   32    fetched instruction
// - instr_valid    out  1     instr presented to decode/datapath
// - instr          out  32    latched instruction
// - instr_ready    in   1     decode accepted instr
// - resolve_valid  in   1     datapath has resolved operands/control this cycle
// - branch         in   3     100 BEQ, 101 BNE, 110 BLEZ, 111 BGTZ, 001 BGEZ, other = none
// - jump           in   2     01 j, 10 jal, 00/11 = none
// - jr             in   1     jump-register
// - rs_val         in   XLEN  rs operand
// - rt_val         in   XLEN  rt operand
// - link_we        out  1     one-cycle pulse: write link_data to r31
// - link_data      out  XLEN  pc+4 of the jal
// - pc             out  XLEN  address of the current instruction
// - addr_fault     out  1     sticky misaligned-target flag (macro only; else tied 0)
// BEHAVIOUR
// - Reset (async, any state):
//   - state=S_FETCH, pc=RESET_PC, instr=0.
//   - imem_req, instr_valid, link_we and addr_fault all 0.
//   - An outstanding fetch is abandoned.
// - S_FETCH:
//   - imem_req = !halt; imem_addr = pc, held stable while waiting.
//   - On imem_req && imem_ready: instr <= imem_rdata, go to S_ISSUE.
//   - If halt rises mid-wait, the request is held until it completes.
// - S_ISSUE: instr_valid=1; on instr_ready go to S_RESOLVE.
// - S_RESOLVE: wait for resolve_valid, then update pc and return to S_FETCH.
// - Best case is 3 cycles per instruction.
// - Next-PC priority: jr > jump > taken branch > sequential.
//   - jr: rs_val
//   - j/jal: {pc4[31:28], instr[25:0], 2'b00}
//   - Taken branch: pc4 + (sext(instr[15:0]) << 2), wrapping mod 2^XLEN
//   - Sequential: pc4 = pc + 4, wrapping
// - Branch conditions (rs/rt compared as signed):
//   - BEQ rs==rt; BNE rs!=rt
//   - BLEZ rs<=0; BGTZ rs>0; BGEZ rs>=0
// - jal: link_we=1 for exactly the resolve cycle, link_data=pc4.
// - resolve_valid outside S_RESOLVE is ignored.
// - A pc update to 0xFFFF_FFFC wraps pc4 to 0.
// CONFIGURATION
// - PCSEQ_ALIGN_CHECK_EN defined:
//   - A next PC with [1:0]!=0 goes to S_TRAP and sets addr_fault=1.
//   - In S_TRAP, pc keeps the faulting instruction's address and no fetch is issued.
//   - Only reset leaves S_TRAP.
// - PCSEQ_ALIGN_CHECK_EN undefined: next PC bits [1:0] are forced to 00, addr_fault tied 0, no S_TRAP.
// STRUCTURE
// - mips_pkg:
//   - localparams BR_BEQ/BR_BNE/BR_BLEZ/BR_BGTZ/BR_BGEZ and JMP_J/JMP_JAL
//   - typedef enum pcseq_state_e {S_FETCH, S_ISSUE, S_RESOLVE, S_TRAP}
// - Sub-module npc_calc (combinational): branch condition + next-PC mux + link value.
// - pc_sequencer holds the FSM and registers.
// TESTING
// - Reset, imem_ready after 2 cycles, rdata=32'h2008_0005
//   -> imem_addr=0, instr=32'h2008_0005, instr_valid; after resolve with no branch, pc=4.
// - pc=0x100, BEQ imm=0xFFFF, rs=rt=7 -> pc=0x100; with rs=7, rt=8 -> pc=0x104.
// - pc=0x4000_0010, jal instr[25:0]=0x40
//   -> pc=0x4000_0100; link_we pulse with link_data=0x4000_0014.
// - jr with jump=01 also set, rs_val=0x8000 -> pc=0x8000 (jr wins).
// - BLEZ rs=0x8000_0000 -> taken; BGTZ with rs=0 -> not taken;
//   BGEZ with rs=0 -> taken; BLEZ with rs=1 -> not taken.
// - rst_n low mid-S_FETCH -> imem_req=0 immediately, pc=RESET_PC.
// - Macro on: jr rs_val=0x102 -> addr_fault=1, imem_req stays 0.
// - Macro off: same stimulus -> pc=0x100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the PC sequencer: branch/jump control codes and FSM states.
package mips_pkg;

    // Branch condition codes returned by the control decoder
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLEZ = 3'b110;
    localparam logic [2:0] BR_BGTZ = 3'b111;
    localparam logic [2:0] BR_BGEZ = 3'b001;

    // Jump codes returned by the control decoder
    localparam logic [1:0] JMP_J   = 2'b01;
    localparam logic [1:0] JMP_JAL = 2'b10;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_ISSUE   = 2'd1,
        S_RESOLVE = 2'd2,
        S_TRAP    = 2'd3
    } pcseq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the fetch, issue and resolve signals seen by the PC sequencer.
// master = sequencer side, slave = memory/decoder/datapath side.
interface pc_sequencer_if #(
    parameter int XLEN = 32
) ();
    logic            halt;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic            resolve_valid;
    logic [2:0]      branch;
    logic [1:0]      jump;
    logic            jr;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            link_we;
    logic [XLEN-1:0] link_data;
    logic [XLEN-1:0] pc;
    logic            addr_fault;

    modport master (
        input  halt, imem_ready, imem_rdata, instr_ready, resolve_valid,
               branch, jump, jr, rs_val, rt_val,
        output imem_req, imem_addr, instr_valid, instr, link_we, link_data,
               pc, addr_fault
    );

    modport slave (
        output halt, imem_ready, imem_rdata, instr_ready, resolve_valid,
               branch, jump, jr, rs_val, rt_val,
        input  imem_req, imem_addr, instr_valid, instr, link_we, link_data,
               pc, addr_fault
    );
endinterface

// File: rtl/pc_sequencer_npc_calc.sv
// Combinational next-PC unit: branch condition evaluation, target
// computation and jr > jump > taken branch > sequential selection.
module npc_calc
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [25:0]     instr_index,
    input  logic [2:0]      branch,
    input  logic [1:0]      jump,
    input  logic            jr,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] npc
);
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] j_target;
    logic            rs_neg;
    logic            rs_zero;
    logic            br_taken;

    // All additions wrap modulo 2^XLEN by construction
    assign pc4       = pc + XLEN'(4);
    assign br_off    = {{(XLEN-18){instr_index[15]}}, instr_index[15:0], 2'b00};
    assign br_target = pc4 + br_off;
    assign j_target  = {pc4[XLEN-1:28], instr_index, 2'b00};

    // Signed comparisons against zero reduce to sign bit and zero test
    assign rs_neg  = rs_val[XLEN-1];
    assign rs_zero = (rs_val == '0);

    // Evaluate the branch condition; unknown codes mean no branch
    always_comb begin
        // NOTE: default first so every path assigns br_taken and no latch is inferred.
        br_taken = 1'b0;
        case (branch)
            BR_BEQ:  br_taken = (rs_val == rt_val);
            BR_BNE:  br_taken = (rs_val != rt_val);
            BR_BLEZ: br_taken = rs_neg || rs_zero;
            BR_BGTZ: br_taken = !rs_neg && !rs_zero;
            BR_BGEZ: br_taken = !rs_neg;
            default: br_taken = 1'b0;
        endcase
    end

    // Select the next PC by priority
    always_comb begin
        npc = pc4;
        if (jr) begin
            npc = rs_val;
        end else if (jump == JMP_J || jump == JMP_JAL) begin
            npc = j_target;
        end else if (br_taken) begin
            npc = br_target;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: multicycle fetch -> issue -> resolve loop, one instruction
// in flight, no delay slot. Best case three cycles per instruction.
// Optional feature macro: PCSEQ_ALIGN_CHECK_EN -- trap on misaligned next PC
// instead of silently clearing the low two bits.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.master bus
);
    pcseq_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            req_hold_q, req_hold_d;
    logic            fetch_req;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] npc;
    logic            is_jal;

    npc_calc #(.XLEN(XLEN)) u_npc_calc (
        .pc          (pc_q),
        .instr_index (instr_q[25:0]),
        .branch      (bus.branch),
        .jump        (bus.jump),
        .jr          (bus.jr),
        .rs_val      (bus.rs_val),
        .rt_val      (bus.rt_val),
        .pc4         (pc4),
        .npc         (npc)
    );

    assign is_jal = (bus.jump == JMP_JAL);

`ifdef PCSEQ_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic misaligned;

    assign misaligned     = |npc[1:0];
    assign bus.addr_fault = fault_q;
`else
    logic [XLEN-1:0] npc_aligned;

    assign npc_aligned    = npc & ~XLEN'(3);
    assign bus.addr_fault = 1'b0;
`endif

    // A request issued while halt was low stays up until the memory answers.
    // Gating with rst_n drops the request the moment reset is asserted,
    // abandoning any outstanding fetch.
    assign fetch_req = rst_n && (!bus.halt || req_hold_q);

    // Next-state and handshake outputs
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        req_hold_d      = 1'b0;
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        bus.link_we     = 1'b0;
`ifdef PCSEQ_ALIGN_CHECK_EN
        fault_d         = fault_q;
`endif
        case (state_q)
            S_FETCH: begin
                bus.imem_req = fetch_req;
                req_hold_d   = fetch_req && !bus.imem_ready;
                if (fetch_req && bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready) begin
                    state_d = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                if (bus.resolve_valid) begin
                    bus.link_we = is_jal;
`ifdef PCSEQ_ALIGN_CHECK_EN
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        pc_d    = npc;
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = npc_aligned;
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef PCSEQ_ALIGN_CHECK_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: instr is architecturally visible, so it is cleared on reset like the rest.
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            req_hold_q <= 1'b0;
`ifdef PCSEQ_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            req_hold_q <= req_hold_d;
`ifdef PCSEQ_ALIGN_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.instr     = instr_q;
    assign bus.link_data = pc4;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based scoreboard: stimulus
// pushes expected fetch addresses, instructions and link values; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_pc_sequencer;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] fetch_q[$];
    logic [31:0] instr_q[$];
    logic [31:0] link_q[$];
    logic [31:0] model_pc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.imem_req && bus.imem_ready) begin
                if (fetch_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL fetch_unexpected: addr %h, none expected", bus.imem_addr);
                end else begin
                    check("fetch_addr", bus.imem_addr, fetch_q.pop_front());
                end
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (instr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL instr_unexpected: instr %h, none expected", bus.instr);
                end else begin
                    check("instr", bus.instr, instr_q.pop_front());
                end
            end
            if (link_q.size() == 0) begin
                check("link_we_spurious", {31'd0, bus.link_we}, 32'd0);
            end else if (bus.link_we) begin
                check("link_data", bus.link_data, link_q.pop_front());
            end
        end
    end

    // One instruction through fetch, issue and resolve, from S_FETCH back to S_FETCH
    task automatic run_instr(input logic [31:0] rdata, input int lat, input logic hold_test,
                             input logic [2:0] br, input logic [1:0] jmp, input logic jr_i,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] exp_npc, input logic link_exp,
                             input logic [31:0] exp_link);
        logic got_it;
        fetch_q.push_back(model_pc);
        instr_q.push_back(rdata);
        if (link_exp) link_q.push_back(exp_link);

        if (hold_test) begin
            bus.halt = 1'b1;
            #1;
            check("halt_blocks_req", {31'd0, bus.imem_req}, 32'd0);
            step();
            check("halt_still_blocks", {31'd0, bus.imem_req}, 32'd0);
            bus.halt = 1'b0;
            step();
            bus.halt = 1'b1;
            #1;
            check("halt_holds_req", {31'd0, bus.imem_req}, 32'd1);
            check("addr_while_wait", bus.imem_addr, model_pc);
        end

        repeat (lat) step();
        bus.imem_rdata = rdata;
        bus.imem_ready = 1'b1;
        got_it = 1'b0;
        for (int i = 0; i < 20 && !got_it; i++) begin
            step();
            got_it = bus.instr_valid;
        end
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.halt       = 1'b0;
        check("issue_valid", {31'd0, bus.instr_valid}, 32'd1);

        // Garbage resolve during issue must be ignored
        bus.instr_ready   = 1'b1;
        bus.resolve_valid = 1'b1;
        bus.jr            = 1'b1;
        bus.rs_val        = 32'hDEAD_0000;
        step();
        bus.instr_ready   = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.jr            = 1'b0;
        bus.rs_val        = 32'h0;
        check("issue_done", {31'd0, bus.instr_valid}, 32'd0);
        step();

        bus.branch        = br;
        bus.jump          = jmp;
        bus.jr            = jr_i;
        bus.rs_val        = rs;
        bus.rt_val        = rt;
        bus.resolve_valid = 1'b1;
        step();
        bus.branch        = 3'b000;
        bus.jump          = 2'b00;
        bus.jr            = 1'b0;
        bus.rs_val        = 32'h0;
        bus.rt_val        = 32'h0;
        bus.resolve_valid = 1'b0;
        check("pc", bus.pc, exp_npc);
        model_pc = exp_npc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus.halt          = 1'b0;
        bus.imem_ready    = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.instr_ready   = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.branch        = 3'b000;
        bus.jump          = 2'b00;
        bus.jr            = 1'b0;
        bus.rs_val        = 32'h0;
        bus.rt_val        = 32'h0;
        model_pc          = 32'h0;

        repeat (2) step();
        check("rst_imem_req",    {31'd0, bus.imem_req},    32'd0);
        check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_link_we",     {31'd0, bus.link_we},     32'd0);
        check("rst_addr_fault",  {31'd0, bus.addr_fault},  32'd0);
        check("rst_pc",          bus.pc,                   32'h0);
        check("rst_instr",       bus.instr,                32'h0);
        rst_n = 1'b1;
        #1;
        check("fetch_req_after_rst", {31'd0, bus.imem_req}, 32'd1);

        // rdata, lat, hold, branch, jump, jr, rs, rt, exp_pc, link?, link_data
        run_instr(32'h2008_0005, 2, 1'b0, 3'b000,  2'b00,   1'b0, 32'h0,         32'h0, 32'h0000_0004, 1'b0, 32'h0);
        run_instr(32'h0000_0008, 0, 1'b0, 3'b000,  2'b00,   1'b1, 32'h0000_0100, 32'h0, 32'h0000_0100, 1'b0, 32'h0);
        run_instr(32'h1000_FFFF, 1, 1'b0, BR_BEQ,  2'b00,   1'b0, 32'd7,         32'd7, 32'h0000_0100, 1'b0, 32'h0);
        run_instr(32'h1000_FFFF, 0, 1'b0, BR_BEQ,  2'b00,   1'b0, 32'd7,         32'd8, 32'h0000_0104, 1'b0, 32'h0);
        run_instr(32'h0000_0008, 0, 1'b0, 3'b000,  2'b00,   1'b1, 32'h4000_0010, 32'h0, 32'h4000_0010, 1'b0, 32'h0);
        run_instr(32'h0C00_0040, 0, 1'b0, 3'b000,  JMP_JAL, 1'b0, 32'h0,         32'h0, 32'h4000_0100, 1'b1, 32'h4000_0014);
        run_instr(32'h0800_0040, 0, 1'b0, 3'b000,  JMP_J,   1'b1, 32'h0000_8000, 32'h0, 32'h0000_8000, 1'b0, 32'h0);
        run_instr(32'h1800_0010, 0, 1'b1, BR_BLEZ, 2'b00,   1'b0, 32'h8000_0000, 32'h0, 32'h0000_8044, 1'b0, 32'h0);
        run_instr(32'h1C00_0010, 0, 1'b0, BR_BGTZ, 2'b00,   1'b0, 32'h0,         32'h0, 32'h0000_8048, 1'b0, 32'h0);
        run_instr(32'h0401_0010, 0, 1'b0, BR_BGEZ, 2'b00,   1'b0, 32'h0,         32'h0, 32'h0000_808C, 1'b0, 32'h0);
        run_instr(32'h1800_0010, 0, 1'b0, BR_BLEZ, 2'b00,   1'b0, 32'h1,         32'h0, 32'h0000_8090, 1'b0, 32'h0);
        run_instr(32'h0000_0008, 0, 1'b0, 3'b000,  2'b00,   1'b1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0);
        run_instr(32'h2008_0005, 0, 1'b0, 3'b000,  2'b00,   1'b0, 32'h0,         32'h0, 32'h0000_0000, 1'b0, 32'h0);
        run_instr(32'h1400_0004, 0, 1'b0, BR_BNE,  2'b00,   1'b0, 32'h1,         32'h2, 32'h0000_0014, 1'b0, 32'h0);
        run_instr(32'h0000_0010, 0, 1'b0, 3'b011,  2'b00,   1'b0, 32'h0,         32'h0, 32'h0000_0018, 1'b0, 32'h0);

        // Reset while a fetch is outstanding
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_fetch_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_mid_fetch_pc",  bus.pc,                 32'h0);
        step();
        rst_n    = 1'b1;
        model_pc = 32'h0;

`ifdef PCSEQ_ALIGN_CHECK_EN
        run_instr(32'h0000_0008, 0, 1'b0, 3'b000, 2'b00, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_0000, 1'b0, 32'h0);
        check("fault_set", {31'd0, bus.addr_fault}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("trap_no_req", {31'd0, bus.imem_req}, 32'd0);
            step();
        end
        check("trap_pc_kept", bus.pc, 32'h0);
`else
        run_instr(32'h0000_0008, 0, 1'b0, 3'b000, 2'b00, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_0100, 1'b0, 32'h0);
        check("no_fault", {31'd0, bus.addr_fault}, 32'd0);
        run_instr(32'h2008_0005, 0, 1'b0, 3'b000, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0104, 1'b0, 32'h0);
`endif

        step();
        check("fetch_q_drained", fetch_q.size(), 32'd0);
        check("instr_q_drained", instr_q.size(), 32'd0);
        check("link_q_drained",  link_q.size(),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
